// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one ram_dpi port between the IFU (read-only) and the LSU (read/write).
// Round-robin arbitration in IDLE, a programmable access delay in ACCESS (one
// memory strobe per transaction), then the response is held in RESP until taken.
//
// State table:
//   state  | meaning
//   IDLE   | no transaction; winner sees req_ready, handshake captures request
//   ACCESS | counting down latency; mem_valid strobes only when cnt==0
//   RESP   | owner's resp_valid high, resp_data held until resp_ready
//
// Ports:
//   clock, reset_n                    clock / async active-low reset
//   ifu_req_*  / ifu_resp_*           IFU read request and response channels
//   lsu_req_*  / lsu_resp_*           LSU read/write request and response channels
//   mem_valid, mem_raddr, mem_wen,
//   mem_waddr, mem_wdata, mem_wmask   ram_dpi drive (zero outside the strobe cycle)
//   mem_rdata                         ram_dpi read data
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [7:0]        lsu_req_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("mem_arbiter: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic              r_last_lsu;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;
  logic [DATA_W-1:0] r_ifu_rdata;
  logic [DATA_W-1:0] r_lsu_rdata;

  logic w_win_ifu;
  logic w_win_lsu;
  logic w_accept;
  logic w_mem_fire;
  logic w_resp_done;

  // LSU wins when alone, or when both request and the IFU had the last grant.
  // Ready is gated by reset_n so every output reads 0 while reset is held.
  assign w_win_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
  assign w_win_ifu = ifu_req_valid && !w_win_lsu;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_mem_fire     = 1'b0;
    w_resp_done    = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        ifu_req_ready = reset_n && w_win_ifu;
        lsu_req_ready = reset_n && w_win_lsu;
        w_accept      = ifu_req_ready || lsu_req_ready;
        if (w_accept) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_mem_fire  = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        ifu_resp_valid = (r_owner == OWN_IFU);
        lsu_resp_valid = (r_owner == OWN_LSU);
        w_resp_done    = (ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready);
        if (w_resp_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= OWN_NONE;
      r_last_lsu  <= 1'b1;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner    <= w_win_lsu ? OWN_LSU : OWN_IFU;
            r_last_lsu <= w_win_lsu;
            r_addr     <= w_win_lsu ? lsu_req_addr : ifu_req_addr;
            r_wen      <= w_win_lsu && lsu_req_wen;
            r_wdata    <= w_win_lsu ? lsu_req_wdata : '0;
            r_wmask    <= w_win_lsu ? lsu_req_wmask : 8'h00;
            r_cnt      <= 4'(LATENCY - 1);
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else if (r_owner == OWN_LSU) r_lsu_rdata <= mem_rdata;
          else r_ifu_rdata <= mem_rdata;
        end
        S_RESP: begin
          if (w_resp_done) r_owner <= OWN_NONE;
        end
        default: ;
      endcase
    end
  end

  // Memory drive is zero everywhere except the single strobe cycle.
  assign mem_valid     = w_mem_fire;
  assign mem_raddr     = w_mem_fire ? r_addr  : '0;
  assign mem_waddr     = w_mem_fire ? r_addr  : '0;
  assign mem_wen       = w_mem_fire && r_wen;
  assign mem_wdata     = w_mem_fire ? r_wdata : '0;
  assign mem_wmask     = w_mem_fire ? r_wmask : 8'h00;
  assign ifu_resp_data = r_ifu_rdata;
  assign lsu_resp_data = r_lsu_rdata;

endmodule
